// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer between NREQ byte producers.
// One byte is accepted per grant; a watchdog aborts frames whose done tick never comes.
//   state  | meaning
//   IDLE   | pick next requester after ptr, pulse its req_ready, capture its byte
//   LAUNCH | tx_start high for one cycle, watchdog cleared
//   WAIT   | wait for tx_done_tick or watchdog expiry
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int TIMEOUT_W = 20,
  parameter int GW        = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_done_tick,
  output logic              busy,
  output logic [GW-1:0]     grant_id,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t               state_q;
  logic [7:0]           hold_q;
  logic [GW-1:0]        ptr_q;
  logic [GW-1:0]        grant_q;
  logic [TIMEOUT_W-1:0] wdog_q;
  logic                 tout_q;

  logic                 found;
  logic [GW-1:0]        win_idx;
  logic [GW-1:0]        idx_v;
  logic [7:0]           win_data;

  // Search starts just after the last winner so it ends up with lowest priority.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    idx_v    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_v = GW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx_v]) begin
        found    = 1'b1;
        win_idx  = idx_v;
        win_data = req_data[{idx_v, 3'b000} +: 8];
      end
    end
  end

  // Gated by reset_n so no accept is signalled while reset is held.
  always_comb begin
    req_ready = '0;
    if (reset_n && state_q == S_IDLE && found) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hold_q  <= 8'h00;
      ptr_q   <= GW'(NREQ - 1);
      grant_q <= '0;
      wdog_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      tout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            hold_q  <= win_data;
            grant_q <= win_idx;
            ptr_q   <= win_idx;
            state_q <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          wdog_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done tick wins over a simultaneous watchdog expiry.
          if (tx_done_tick) begin
            state_q <= S_IDLE;
          end else if (&wdog_q) begin
            tout_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + TIMEOUT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start    = (state_q == S_LAUNCH);
  assign busy        = (state_q != S_IDLE);
  assign tx_din      = hold_q;
  assign grant_id    = grant_q;
  assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus hand-written
// timeout, done/timeout race and mid-frame reset sequences.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int TIMEOUT_W = 6;
  localparam int GW        = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              tx_done_tick;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT_W(TIMEOUT_W), .GW(GW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        done;
    logic [3:0]  ready;
    logic        start;
    logic        bsy;
    logic [1:0]  grant;
    logic [7:0]  din;
    logic        tout;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic dn,
                              input logic [3:0] r, input logic s, input logic b,
                              input logic [1:0] g, input logic [7:0] di, input logic t);
    vec_t x;
    x.valid = v; x.data = d; x.done = dn; x.ready = r; x.start = s;
    x.bsy = b; x.grant = g; x.din = di; x.tout = t;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] D   = 32'h44332211;
  localparam logic [31:0] DFF = 32'h443322FF;

  initial begin
    int cnt;
    reset_n = 1'b0; req_valid = '0; req_data = '0; tx_done_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("reset busy", busy, 0);
    chk("reset tx_start", tx_start, 0);
    chk("reset tx_din", tx_din, 0);
    chk("reset timeout_err", timeout_err, 0);

    //           valid   data          dn ready   st bs g  din    to
    vt.push_back(mk(4'b0100, 32'h00A50000, 0, 4'b0100, 0, 0, 0, 8'h00, 0));
    vt.push_back(mk(4'b0000, 32'h00A50000, 0, 4'b0000, 1, 1, 2, 8'hA5, 0));
    vt.push_back(mk(4'b0000, 32'h00000000, 0, 4'b0000, 0, 1, 2, 8'hA5, 0));
    vt.push_back(mk(4'b0000, 32'h00000000, 1, 4'b0000, 0, 1, 2, 8'hA5, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b1000, 0, 0, 2, 8'hA5, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0000, 1, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b1111, D,   1, 4'b0000, 0, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0001, 0, 0, 3, 8'h44, 0));
    vt.push_back(mk(4'b1111, DFF, 0, 4'b0000, 1, 1, 0, 8'h11, 0));
    vt.push_back(mk(4'b1111, DFF, 1, 4'b0000, 0, 1, 0, 8'h11, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0010, 0, 0, 0, 8'h11, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0000, 1, 1, 1, 8'h22, 0));
    vt.push_back(mk(4'b1111, D,   1, 4'b0000, 0, 1, 1, 8'h22, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0100, 0, 0, 1, 8'h22, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0000, 1, 1, 2, 8'h33, 0));
    vt.push_back(mk(4'b1111, D,   1, 4'b0000, 0, 1, 2, 8'h33, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b1000, 0, 0, 2, 8'h33, 0));
    vt.push_back(mk(4'b1111, D,   1, 4'b0000, 1, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b1111, D,   0, 4'b0000, 0, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b0000, D,   1, 4'b0000, 0, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b0000, D,   1, 4'b0000, 0, 0, 3, 8'h44, 0));
    vt.push_back(mk(4'b1010, D,   0, 4'b0010, 0, 0, 3, 8'h44, 0));
    vt.push_back(mk(4'b1010, D,   0, 4'b0000, 1, 1, 1, 8'h22, 0));
    vt.push_back(mk(4'b1010, D,   1, 4'b0000, 0, 1, 1, 8'h22, 0));
    vt.push_back(mk(4'b1010, D,   0, 4'b1000, 0, 0, 1, 8'h22, 0));
    vt.push_back(mk(4'b1010, D,   0, 4'b0000, 1, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b1010, D,   1, 4'b0000, 0, 1, 3, 8'h44, 0));
    vt.push_back(mk(4'b1010, D,   0, 4'b0010, 0, 0, 3, 8'h44, 0));
    vt.push_back(mk(4'b1010, D,   0, 4'b0000, 1, 1, 1, 8'h22, 0));
    vt.push_back(mk(4'b0000, D,   1, 4'b0000, 0, 1, 1, 8'h22, 0));
    vt.push_back(mk(4'b0000, D,   0, 4'b0000, 0, 0, 1, 8'h22, 0));

    for (int i = 0; i < vt.size(); i++) begin
      req_valid = vt[i].valid; req_data = vt[i].data; tx_done_tick = vt[i].done;
      #1;
      chk($sformatf("row%0d req_ready", i), req_ready, vt[i].ready);
      chk($sformatf("row%0d tx_start", i), tx_start, vt[i].start);
      chk($sformatf("row%0d busy", i), busy, vt[i].bsy);
      chk($sformatf("row%0d grant_id", i), grant_id, vt[i].grant);
      chk($sformatf("row%0d tx_din", i), tx_din, vt[i].din);
      chk($sformatf("row%0d timeout_err", i), timeout_err, vt[i].tout);
      step();
    end

    // Timeout: ptr=1 now; wdog runs 0..63 across 64 WAIT cycles before abort.
    req_valid = 4'b0100; req_data = 32'h00C30000; tx_done_tick = 1'b0;
    #1 chk("to req_ready", req_ready, 4'b0100);
    step();
    req_valid = '0;
    #1 chk("to tx_start", tx_start, 1);
    chk("to tx_din", tx_din, 8'hC3);
    step();
    cnt = 0;
    while (!timeout_err && cnt < 200) begin
      if (tx_start) chk("to no restart", tx_start, 0);
      step();
      cnt++;
    end
    chk("to wait cycles", cnt, 64);
    chk("to pulse", timeout_err, 1);
    chk("to busy after", busy, 0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    #1 chk("to pulse width", timeout_err, 0);
    chk("to idle done ignored", busy, 0);
    req_valid = 4'b1001; req_data = D;
    #1 chk("to next ready", req_ready, 4'b1000);
    step();
    req_valid = '0;
    #1 chk("to next start", tx_start, 1);
    chk("to next grant", grant_id, 3);
    step();

    // Race: done tick in the same cycle wdog reaches all-ones.
    repeat (63) step();
    chk("race still busy", busy, 1);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    #1 chk("race no timeout", timeout_err, 0);
    chk("race idle", busy, 0);
    step();
    chk("race no late timeout", timeout_err, 0);

    // Reset in the middle of WAIT.
    req_valid = 4'b0010; req_data = D;
    #1 chk("rst ready", req_ready, 4'b0001 << 1);
    step();
    req_valid = '0;
    step();
    step();
    chk("rst pre busy", busy, 1);
    req_valid = 4'b1111;
    #2 reset_n = 1'b0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst tx_start", tx_start, 0);
    chk("rst req_ready", req_ready, 4'b0000);
    chk("rst tx_din", tx_din, 8'h00);
    chk("rst grant_id", grant_id, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("rst timeout_err", timeout_err, 0);
    chk("rst first winner", req_ready, 4'b0001);
    step();
    req_valid = '0;
    #1 chk("rst launch grant", grant_id, 0);
    chk("rst launch din", tx_din, 8'h11);
    chk("rst launch start", tx_start, 1);
    step();
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("rst final idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
